// File: rtl/sdram_traffic_gen_if.sv
// rtl/sdram_traffic_gen_if.sv - trigger/handshake bundle between the traffic generator and sdram_top
interface sdram_traffic_gen_if #(
    parameter int DATA_W = 16
);
    logic              init_done;
    logic              wr_trig;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              rd_trig;
    logic              rd_data_vld;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;

    modport master (
        input  init_done, wr_req, wr_done, rd_data_vld, rd_data, rd_done,
        output wr_trig, wr_data, rd_trig
    );

    modport slave (
        output init_done, wr_req, wr_done, rd_data_vld, rd_data, rd_done,
        input  wr_trig, wr_data, rd_trig
    );
endinterface

// File: rtl/sdram_traffic_gen.sv
// rtl/sdram_traffic_gen.sv - write/read-back pattern traffic source and checker for sdram_top
// Define SDRAM_TG_LFSR_EN for LFSR patterns; default build uses incrementing counters.
module sdram_traffic_gen #(
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] SEED    = '0,
    parameter int unsigned       TIMEOUT = 20000
) (
    input  logic                    sclk,
    input  logic                    s_rst,
    input  logic                    start,
    sdram_traffic_gen_if.master     bus,
    output logic                    busy,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [15:0]             err_cnt,
    output logic [15:0]             first_err_idx
);
    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, WR_TRIG, WR_WAIT, RD_TRIG, RD_WAIT, DONE
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wr_gen_q, wr_gen_d;
    logic [DATA_W-1:0] chk_gen_q, chk_gen_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       first_err_q, first_err_d;
    logic              pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic              busy_q, busy_d, wr_trig_q, wr_trig_d, rd_trig_q, rd_trig_d;
    logic              tmo_hit;

    function automatic logic [DATA_W-1:0] gen_next(input logic [DATA_W-1:0] w);
`ifdef SDRAM_TG_LFSR_EN
        gen_next = {w[DATA_W-2:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
`else
        gen_next = w + {{(DATA_W-1){1'b0}}, 1'b1};
`endif
    endfunction

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        wr_gen_d    = wr_gen_q;
        chk_gen_d   = chk_gen_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = 16'hFFFF;
                    wr_gen_d    = SEED;
                    chk_gen_d   = SEED;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    state_d     = WAIT_INIT;
                end
            end
            WAIT_INIT: if (bus.init_done) state_d = WR_TRIG;
            WR_TRIG: begin
                tmo_cnt_d = '0;
                state_d   = WR_WAIT;
            end
            WR_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (bus.wr_req) begin
                    wr_gen_d = gen_next(wr_gen_q);
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
                if (bus.wr_done) begin
                    chk_gen_d = SEED;
                    state_d   = RD_TRIG;
                end else if (tmo_hit) begin
                    pass_d    = 1'b0;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            RD_TRIG: begin
                tmo_cnt_d = '0;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (bus.rd_data_vld) begin
                    chk_gen_d = gen_next(chk_gen_q);
                    rd_cnt_d  = rd_cnt_q + 16'd1;
                    if (bus.rd_data != chk_gen_q) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (err_cnt_q == 16'd0)    first_err_d = rd_cnt_q;
                    end
                end
                // Verdict uses the post-update counts so a final word beside rd_done is included.
                if (bus.rd_done) begin
                    pass_d  = (err_cnt_d == 16'd0) && (rd_cnt_d == wr_cnt_q);
                    fail_d  = !pass_d;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    pass_d    = 1'b0;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_trig_d = (state_d == WR_TRIG);
        rd_trig_d = (state_d == RD_TRIG);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q     <= IDLE;
            wr_gen_q    <= SEED;
            chk_gen_q   <= SEED;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= 16'hFFFF;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_trig_q   <= 1'b0;
            rd_trig_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_gen_q    <= wr_gen_d;
            chk_gen_q   <= chk_gen_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            wr_trig_q   <= wr_trig_d;
            rd_trig_q   <= rd_trig_d;
        end
    end

    assign bus.wr_trig    = wr_trig_q;
    assign bus.rd_trig    = rd_trig_q;
    assign bus.wr_data    = wr_gen_q;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_err_q;
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb/tb_sdram_traffic_gen.sv - directed and randomized checks of sdram_traffic_gen against a pattern model
module tb_sdram_traffic_gen;
    localparam int          DW     = 16;
    localparam logic [15:0] SEED_P = 16'h0000;
    localparam int          TMO    = 1000;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic        start;
    logic        busy, pass, fail, timeout;
    logic [15:0] err_cnt, first_err_idx;
    int          n_tests = 0;
    int          n_fail  = 0;

    sdram_traffic_gen_if #(.DATA_W(DW)) bus ();

    sdram_traffic_gen #(.DATA_W(DW), .SEED(SEED_P), .TIMEOUT(TMO)) dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    // Expected pattern: the k-th word of a run is SEED + k modulo 2^16.
    function automatic logic [15:0] exp_word(input int k);
        return 16'(SEED_P + 16'(k));
    endfunction

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        bus.init_done = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        step();
        check("wr_trig_pulse", bus.wr_trig, 1);
        step();
        check("wr_trig_end", bus.wr_trig, 0);
    endtask

    task automatic run_body(input int n_wr, input int n_rd, input logic [31:0] corrupt,
                            input logic [15:0] fmask, input bit merge_wr, input bit merge_rd,
                            input bit gaps);
        int          m_err;
        logic [15:0] m_first;
        logic [15:0] word;
        bit          exp_pass;
        m_err   = 0;
        m_first = 16'hFFFF;
        for (int k = 0; k < n_wr; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            check("wr_data", bus.wr_data, exp_word(k));
            bus.wr_req  = 1'b1;
            bus.wr_done = merge_wr && (k == n_wr - 1);
            step();
            bus.wr_req  = 1'b0;
            bus.wr_done = 1'b0;
        end
        if (!merge_wr || n_wr == 0) begin
            bus.wr_done = 1'b1;
            step();
            bus.wr_done = 1'b0;
        end
        check("rd_trig_pulse", bus.rd_trig, 1);
        step();
        check("rd_trig_end", bus.rd_trig, 0);
        for (int k = 0; k < n_rd; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            word = exp_word(k);
            if (corrupt[k]) begin
                word = word ^ ((fmask != 16'd0) ? fmask : 16'($urandom_range(1, 65535)));
                m_err++;
                if (m_first == 16'hFFFF) m_first = 16'(k);
            end
            bus.rd_data     = word;
            bus.rd_data_vld = 1'b1;
            bus.rd_done     = merge_rd && (k == n_rd - 1);
            step();
            bus.rd_data_vld = 1'b0;
            bus.rd_done     = 1'b0;
            check("err_cnt_live", err_cnt, m_err);
            check("first_err_live", first_err_idx, m_first);
        end
        if (!merge_rd || n_rd == 0) begin
            bus.rd_done = 1'b1;
            step();
            bus.rd_done = 1'b0;
        end
        exp_pass = (m_err == 0) && (n_rd == n_wr);
        check("pass", pass, exp_pass);
        check("fail", fail, !exp_pass);
        check("timeout_clear", timeout, 0);
        check("err_cnt", err_cnt, m_err);
        check("first_err_idx", first_err_idx, m_first);
        check("busy_in_done", busy, 1);
        step();
        check("busy_fall", busy, 0);
        check("pass_sticky", pass, exp_pass);
    endtask

    initial begin
        bit          early;
        int          nw, nr;
        logic [31:0] cmask;
        s_rst = 1'b1;
        start = 1'b0;
        bus.init_done = 1'b0; bus.wr_req = 1'b0; bus.wr_done = 1'b0;
        bus.rd_data_vld = 1'b0; bus.rd_data = '0; bus.rd_done = 1'b0;
        step(); step();
        s_rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err_idx, 16'hFFFF);
        check("rst_wr_data", bus.wr_data, SEED_P);
        check("rst_wr_trig", bus.wr_trig, 0);

        // init_done arrives late: wr_trig must wait for it
        start = 1'b1;
        step();
        start = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (bus.wr_trig) early = 1'b1;
        end
        check("no_early_wr_trig", early, 0);
        bus.init_done = 1'b1;
        step();
        check("wr_trig_after_init", bus.wr_trig, 1);
        step();
        check("wr_trig_single", bus.wr_trig, 0);
        run_body(8, 8, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // wr_req in IDLE must not advance the pattern
        bus.wr_req = 1'b1;
        step();
        bus.wr_req = 1'b0;
        check("idle_wr_req_ignored", bus.wr_data, exp_word(8));

        do_start();
        run_body(8, 8, 32'h8, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_start();
        run_body(8, 7, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            nw = $urandom_range(1, 12);
            case ($urandom_range(0, 2))
                0:       nr = nw;
                1:       nr = nw - 1;
                default: nr = nw + 1;
            endcase
            cmask = ($urandom_range(0, 1) != 0) ? ($urandom & $urandom) : 32'h0;
            do_start();
            run_body(nw, nr, cmask, 16'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        // no wr_done: abort after TMO cycles in WR_WAIT
        do_start();
        early = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            if (fail || timeout || bus.rd_trig) early = 1'b1;
        end
        check("no_early_timeout", early, 0);
        step();
        check("tmo_fail", fail, 1);
        check("tmo_flag", timeout, 1);
        check("tmo_pass", pass, 0);
        step();
        check("tmo_busy_fall", busy, 0);
        check("tmo_no_rd_trig", bus.rd_trig, 0);

        // reset in the middle of RD_WAIT
        do_start();
        for (int k = 0; k < 4; k++) begin
            bus.wr_req = 1'b1;
            step();
        end
        bus.wr_req  = 1'b0;
        bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0;
        step();
        bus.rd_data     = exp_word(0) ^ 16'h00F0;
        bus.rd_data_vld = 1'b1;
        step();
        bus.rd_data_vld = 1'b0;
        check("pre_rst_err", err_cnt, 1);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_fail", fail, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_first", first_err_idx, 16'hFFFF);
        check("mid_rst_wr_data", bus.wr_data, SEED_P);
        do_start();
        run_body(5, 5, 32'h0, 16'h0, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
